// File: rtl/lock_ctrl_fsm_pkg.sv
// Shared types and constants for the keypad lock controller.
// Holds the FSM state encoding, digit limit, defaults and the wrong-count display helper.
package lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_CHECK = 3'd2,
        S_OPEN  = 3'd3,
        S_LOCK  = 3'd4
    } lock_state_t;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

    localparam int DEF_MAX_DIGITS  = 4;
    localparam int DEF_OPEN_CYCLES = 1000;
    localparam int DEF_MAX_WRONG   = 3;

    // Thermometer code for the wrong-attempt LEDs.
    function automatic logic [2:0] wrong_therm(input logic [1:0] w);
        case (w)
            2'd0:    wrong_therm = 3'b000;
            2'd1:    wrong_therm = 3'b001;
            2'd2:    wrong_therm = 3'b011;
            default: wrong_therm = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lock_ctrl_fsm_btn_rise.sv
// Rising-edge detector for the three front-panel buttons.
// A button held through reset release reads as an edge on the first cycle.
module btn_rise (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    output logic [2:0] rise
);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_bit
            logic hist_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hist_reg <= 1'b0;
                end else begin
                    hist_reg <= btn[gi];
                end
            end

            assign rise[gi] = btn[gi] & ~hist_reg;
        end
    endgenerate

endmodule

// File: rtl/lock_ctrl_fsm.sv
// Keypad password lock sequencer: password storage, entry buffer, compare,
// wrong-attempt counter, open timer and registered status/display outputs.
module lock_ctrl_fsm
    import lock_pkg::*;
#(
    parameter int MAX_DIGITS  = DEF_MAX_DIGITS,
    parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
    parameter int MAX_WRONG   = DEF_MAX_WRONG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        set,
    input  logic        check,
    input  logic        confirm,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        set_led,
    output logic [2:0]  ledwrong,
    output logic        unlock,
    output logic        alarm,
    output logic [31:0] disp_digits,
    output logic [7:0]  disp_mask
);

    localparam int TW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    logic [2:0] rise;
    logic       set_rise, check_rise, confirm_rise;

    btn_rise u_btn_rise (
        .clk  (clk),
        .rst  (rst),
        .btn  ({confirm, check, set}),
        .rise (rise)
    );

    assign set_rise     = rise[0];
    assign check_rise   = rise[1];
    assign confirm_rise = rise[2];

    lock_state_t state_reg, state_next;
    logic [31:0] buf_reg, buf_next;
    logic [7:0]  mask_reg, mask_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] pw_buf_reg, pw_buf_next;
    logic [3:0]  pw_len_reg, pw_len_next;
    logic        pw_valid_reg, pw_valid_next;
    logic [1:0]  wrong_reg, wrong_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic        set_led_reg, unlock_reg, alarm_reg;
    logic [2:0]  ledwrong_reg;

    logic       digit;
    logic       in_entry;
    logic       match;
    logic [1:0] wrong_inc;

    assign digit     = key_valid && (key_code <= KEY_DIGIT_MAX);
    assign in_entry  = (state_reg == S_SET) || (state_reg == S_CHECK);
    // Unused upper nibbles are always zero in both buffers, so a full-width compare is exact.
    assign match     = (cnt_reg == pw_len_reg) && (buf_reg == pw_buf_reg);
    assign wrong_inc = wrong_reg + 2'd1;

    always_comb begin
        state_next    = state_reg;
        pw_buf_next   = pw_buf_reg;
        pw_len_next   = pw_len_reg;
        pw_valid_next = pw_valid_reg;
        wrong_next    = wrong_reg;
        timer_next    = timer_reg;

        case (state_reg)
            S_IDLE: begin
                if (set_rise && !pw_valid_reg) begin
                    state_next = S_SET;
                end else if (check_rise && pw_valid_reg) begin
                    state_next = S_CHECK;
                end
            end
            S_SET: begin
                if (confirm_rise) begin
                    if (cnt_reg != 4'd0) begin
                        pw_buf_next   = buf_reg;
                        pw_len_next   = cnt_reg;
                        pw_valid_next = 1'b1;
                        wrong_next    = 2'd0;
                    end
                    state_next = S_IDLE;
                end
            end
            S_CHECK: begin
                if (confirm_rise) begin
                    if (match) begin
                        wrong_next = 2'd0;
                        timer_next = TW'(OPEN_CYCLES - 1);
                        state_next = S_OPEN;
                    end else begin
                        wrong_next = wrong_inc;
                        state_next = (wrong_inc >= 2'(MAX_WRONG)) ? S_LOCK : S_IDLE;
                    end
                end
            end
            S_OPEN: begin
                if (set_rise) begin
                    state_next = S_SET;
                end else if (timer_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            S_LOCK: begin
                state_next = S_LOCK;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Any state change enters or leaves an entry state, or passes through idle/open
    // where the buffer is already empty, so clearing on every transition is safe.
    always_comb begin
        buf_next  = buf_reg;
        mask_next = mask_reg;
        cnt_next  = cnt_reg;
        if (state_next != state_reg) begin
            buf_next  = '0;
            mask_next = '0;
            cnt_next  = '0;
        end else if (in_entry && digit && (cnt_reg < 4'(MAX_DIGITS))) begin
            buf_next  = {buf_reg[27:0], key_code};
            mask_next = {mask_reg[6:0], 1'b1};
            cnt_next  = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            buf_reg      <= '0;
            mask_reg     <= '0;
            cnt_reg      <= '0;
            pw_buf_reg   <= '0;
            pw_len_reg   <= '0;
            pw_valid_reg <= 1'b0;
            wrong_reg    <= '0;
            timer_reg    <= '0;
            set_led_reg  <= 1'b0;
            unlock_reg   <= 1'b0;
            alarm_reg    <= 1'b0;
            ledwrong_reg <= '0;
        end else begin
            state_reg    <= state_next;
            buf_reg      <= buf_next;
            mask_reg     <= mask_next;
            cnt_reg      <= cnt_next;
            pw_buf_reg   <= pw_buf_next;
            pw_len_reg   <= pw_len_next;
            pw_valid_reg <= pw_valid_next;
            wrong_reg    <= wrong_next;
            timer_reg    <= timer_next;
            set_led_reg  <= (state_next == S_SET);
            unlock_reg   <= (state_next == S_OPEN);
            alarm_reg    <= (state_next == S_LOCK);
            ledwrong_reg <= (state_next == S_LOCK) ? 3'b111 : wrong_therm(wrong_next);
        end
    end

    assign set_led     = set_led_reg;
    assign unlock      = unlock_reg;
    assign alarm       = alarm_reg;
    assign ledwrong    = ledwrong_reg;
    assign disp_digits = buf_reg;
    assign disp_mask   = mask_reg;

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// Directed bench for the keypad lock controller with a short open time.
module tb_lock_ctrl_fsm;

    localparam int OPEN = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set = 1'b0, check = 1'b0, confirm = 1'b0, key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        set_led, unlock, alarm;
    logic [2:0]  ledwrong;
    logic [31:0] disp_digits;
    logic [7:0]  disp_mask;

    int total = 0;
    int bad   = 0;
    int n;

    lock_ctrl_fsm #(.MAX_DIGITS(4), .OPEN_CYCLES(OPEN), .MAX_WRONG(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .set         (set),
        .check       (check),
        .confirm     (confirm),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .set_led     (set_led),
        .ledwrong    (ledwrong),
        .unlock      (unlock),
        .alarm       (alarm),
        .disp_digits (disp_digits),
        .disp_mask   (disp_mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // b = {set, check, confirm}
    task automatic pulse(input logic [2:0] b);
        {set, check, confirm} = b;
        tick();
        {set, check, confirm} = 3'b000;
        tick();
    endtask

    task automatic press_key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic type_digits(input logic [31:0] seq, input int cnt);
        for (int i = cnt - 1; i >= 0; i--) press_key(seq[i*4 +: 4]);
    endtask

    task automatic wait_closed();
        int w = 0;
        while (unlock && w < 50) begin
            tick();
            w++;
        end
        chk("open_timeout", {31'd0, unlock}, 32'd0);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk(tag, {set_led, unlock, alarm, ledwrong, disp_mask, disp_digits[15:0]}, 32'd0);
    endtask

    initial begin
        // 1: reset and password 123
        tick(); tick();
        chk_idle_zero("in_reset");
        rst = 1'b0;
        tick();
        chk_idle_zero("after_reset");
        chk("rst_digits", disp_digits, 32'd0);
        pulse(3'b100);
        chk("set_led_on", {31'd0, set_led}, 32'd1);
        type_digits(32'h123, 3);
        chk("entry_123", disp_digits, 32'h123);
        chk("mask_123", {24'd0, disp_mask}, 32'h07);
        pulse(3'b001);
        chk("set_done", {set_led, disp_mask, disp_digits[11:0]}, 32'd0);

        // 2: correct check, open length, password change from open
        pulse(3'b010);
        type_digits(32'h123, 3);
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
        n = 0;
        while (unlock && n < 100) begin
            n++;
            tick();
        end
        chk("open_cycles", n, OPEN);
        chk("ledwrong_ok", {29'd0, ledwrong}, 32'd0);
        pulse(3'b100);
        chk("set_in_idle", {31'd0, set_led}, 32'd0);
        pulse(3'b010);
        type_digits(32'h123, 3);
        pulse(3'b001);
        chk("reopen", {31'd0, unlock}, 32'd1);
        pulse(3'b100);
        chk("set_from_open", {set_led, unlock}, 32'd2);
        type_digits(32'h54, 2);
        pulse(3'b001);
        pulse(3'b010);
        type_digits(32'h54, 2);
        pulse(3'b001);
        chk("new_pw_54", {31'd0, unlock}, 32'd1);
        wait_closed();

        // 3: reset erases password, three wrong checks lock out
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pulse(3'b010);
        press_key(4'd1);
        chk("check_no_pw", {23'd0, set_led, disp_mask}, 32'd0);
        pulse(3'b100);
        type_digits(32'h123, 3);
        pulse(3'b001);
        pulse(3'b010);
        type_digits(32'h543, 3);
        pulse(3'b001);
        chk("wrong1", {28'd0, alarm, ledwrong}, 32'h1);
        pulse(3'b010);
        type_digits(32'h543, 3);
        pulse(3'b001);
        chk("wrong2", {28'd0, alarm, ledwrong}, 32'h3);
        pulse(3'b010);
        type_digits(32'h543, 3);
        pulse(3'b001);
        chk("wrong3_lock", {28'd0, alarm, ledwrong}, 32'hF);
        pulse(3'b100);
        pulse(3'b010);
        press_key(4'd1);
        pulse(3'b001);
        chk("lock_holds", {set_led, unlock, alarm, ledwrong, disp_mask}, 32'h0F00);
        #2 rst = 1'b1;
        #1 chk_idle_zero("lock_rst");
        #1 rst = 1'b0;
        tick();

        // 4: length and boundary cases
        pulse(3'b100);
        type_digits(32'h123, 3);
        pulse(3'b001);
        pulse(3'b010);
        pulse(3'b100);
        chk("set_in_check", {31'd0, set_led}, 32'd0);
        type_digits(32'h1234, 4);
        chk("entry_1234", disp_digits, 32'h1234);
        pulse(3'b001);
        chk("len_long", {28'd0, unlock, ledwrong}, 32'h1);
        pulse(3'b010);
        type_digits(32'h123, 3);
        pulse(3'b001);
        chk("clear_wrong", {28'd0, unlock, ledwrong}, 32'h8);
        wait_closed();
        pulse(3'b010);
        type_digits(32'h12, 2);
        pulse(3'b001);
        chk("len_short", {28'd0, unlock, ledwrong}, 32'h1);
        pulse(3'b010);
        type_digits(32'h123456, 6);
        for (int k = 10; k <= 14; k++) press_key(4'(k));
        chk("six_digits", disp_digits, 32'h1234);
        chk("six_mask", {24'd0, disp_mask}, 32'h0F);
        pulse(3'b001);
        chk("trunc_wrong", {28'd0, unlock, ledwrong}, 32'h3);
        pulse(3'b010);
        type_digits(32'h123, 3);
        pulse(3'b001);
        chk("ok_again", {28'd0, unlock, ledwrong}, 32'h8);
        wait_closed();
        pulse(3'b010);
        pulse(3'b001);
        chk("empty_wrong", {28'd0, unlock, ledwrong}, 32'h1);

        // 5: simultaneous set/check, key coincident with confirm
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        pulse(3'b110);
        chk("set_prio", {31'd0, set_led}, 32'd1);
        press_key(4'd7);
        key_valid = 1'b1;
        key_code  = 4'd8;
        confirm   = 1'b1;
        tick();
        key_valid = 1'b0;
        confirm   = 1'b0;
        tick();
        chk("coincident_end", {23'd0, set_led, disp_mask}, 32'd0);
        pulse(3'b010);
        type_digits(32'h7, 1);
        pulse(3'b001);
        chk("pw_is_7", {31'd0, unlock}, 32'd1);
        wait_closed();

        // 6: asynchronous reset mid-check
        pulse(3'b010);
        press_key(4'd1);
        chk("mid_check", {24'd0, disp_mask}, 32'h01);
        #2 rst = 1'b1;
        #1 chk_idle_zero("async_rst");
        #1 rst = 1'b0;
        tick();
        pulse(3'b010);
        press_key(4'd5);
        chk("post_rst_chk", {23'd0, set_led, disp_mask}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lock_ctrl_fsm.md
Name: lock_ctrl_fsm

Overview:
Central sequencing controller for the keypad password lock. It consumes decoded key events from the 4x4 keypad scanner and the set/check/confirm buttons. It owns the stored password, the entry buffer, the wrong-attempt counter and the open timer. It drives set_led, ledwrong, the unlock/alarm status and the digit buffer for the 8-digit seven-segment display driver.

Parameters:
MAX_DIGITS, 4, maximum password/entry length in decimal digits (1..8)
OPEN_CYCLES, 1000, clk cycles unlock stays high after a correct check
MAX_WRONG, 3, consecutive wrong checks that force lockout (1..3)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
set  input  1  set-password button, level, synchronous to clk
check  input  1  check-password button, level
confirm  input  1  confirm-entry button, level
key_valid  input  1  one-cycle pulse per keypad press from the scanner
key_code  input  4  key value 0x0..0xF, qualified by key_valid
set_led  output  1  high while in S_SET
ledwrong  output  3  thermometer of wrong count: 000/001/011/111
unlock  output  1  high while in S_OPEN
alarm  output  1  high while in S_LOCK
disp_digits  output  32  8 BCD nibbles; entered digits right-aligned, newest in [3:0]
disp_mask  output  8  bit i set = nibble i is valid for display

Behaviour:
- Reset: rst is asynchronous and active-high, on the single clock clk. All outputs go to 0. State = S_IDLE. pw_valid=0, stored password cleared, entry buffer/count cleared, wrong count=0, button history regs=0.
- set/check/confirm are rising-edge detected internally (1-cycle registered history). A button held through reset release fires once on the first cycle.
- Only key_valid with key_code <= 9 is a digit. Codes A–F are ignored. key_valid with key_code > 9 has no effect in any state.
- Digit accepted only in S_SET/S_CHECK while entry_cnt < MAX_DIGITS. Digits beyond MAX_DIGITS are dropped silently. On accept: buffer shifts left one nibble, new digit enters [3:0], entry_cnt++, mask shifts in a 1. Display updates the cycle after key_valid.
- States:
  - S_IDLE:
    - set edge && !pw_valid -> S_SET.
    - else check edge && pw_valid -> S_CHECK.
    - set has priority when both edges land in the same cycle. check with !pw_valid is ignored.
  - S_SET (set_led=1):
    - confirm edge with entry_cnt>0 -> store buffer+length, pw_valid=1, wrong=0 -> S_IDLE.
    - confirm edge with entry_cnt=0 -> password unchanged -> S_IDLE.
  - S_CHECK, on confirm edge:
    - Match requires length equal AND all digits equal -> wrong=0, load open timer -> S_OPEN.
    - Otherwise wrong++. If wrong reaches MAX_WRONG -> S_LOCK, else -> S_IDLE.
    - entry_cnt=0 counts as wrong.
  - S_OPEN (unlock=1): timer decrements each cycle; at 0 -> S_IDLE. set edge -> S_SET (password change is allowed only here or when none is set). check is ignored.
  - S_LOCK (alarm=1, ledwrong=111): every input is ignored; only rst exits.
- The entry buffer, count and mask are cleared on every entry into S_SET/S_CHECK and on every exit from them. The display is blank outside entry states.
- set/check edges inside entry states are ignored; confirm edges outside entry states are ignored.
- A key_valid in the same cycle as a confirm edge: confirm is evaluated on the buffer as it was before that digit, and the digit is dropped.
- All outputs are registered; state-to-output latency is 1 cycle.
- rst mid-entry or mid-open aborts immediately to the reset values, including erasing the password.

Decomposition:
- Package lock_pkg holds:
  - state enum S_IDLE/S_SET/S_CHECK/S_OPEN/S_LOCK
  - KEY_DIGIT_MAX=9
  - the ledwrong thermometer function
  - default parameter constants
- Sub-module btn_rise: a 3-bit rising-edge detector with async active-high reset, instantiated once for set/check/confirm.
- Entry buffer, compare, counters and FSM live in lock_ctrl_fsm.

Test Plan:
1. Reset, set pulse, keys 1,2,3, confirm -> set_led high during entry; disp_digits[11:0]=0x123, disp_mask=0000_0111; after confirm pw_valid=1, state S_IDLE.
2. check, keys 1,2,3, confirm -> unlock=1 for exactly OPEN_CYCLES cycles, ledwrong=000; set during S_OPEN, keys 5,4, confirm -> new password 54 is accepted.
3. With password 123: three checks of 5,4,3 -> ledwrong 001, then 011, then 111 with alarm=1; further set/check/keys produce no change; rst clears everything; check with no password is ignored.
4. Length/boundary: password 123 then check 1,2,3,4 -> wrong; entering 6 digits with MAX_DIGITS=4 keeps the first 4; keys A–E are ignored; check of 1,2 then confirm -> wrong.
5. Simultaneity: set and check edges in the same cycle in S_IDLE (no password) -> S_SET; key_valid coincident with confirm -> the digit is not stored.
6. rst asserted mid-S_CHECK asynchronously (between clk edges) -> outputs go to 0 immediately, pw_valid=0, and the next check is ignored.
